// File: rtl/adc_pkt_pkg.sv
// Shared types and helpers for the ADC capture packet receiver.
package adc_pkt_pkg;

    // Receiver FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        DROP = 2'd2
    } rx_state_e;

    // Packet length selector: 00=216, 01=432, 10=864, 11=1728 words
    typedef logic [1:0] len_type_t;

    localparam int unsigned LEN_216 = 216;

    // Expected packet length for a given length type (fits in 11 bits)
    function automatic logic [10:0] exp_len(input len_type_t len_type);
        return 11'(LEN_216 << len_type);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    // Count up on inc, never wrapping past all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/adc_pkt_rx.sv
// Receive-side deframer for the ADC capture packet stream: delimits
// packets, checks length and inter-packet gap, forwards framed words
// and keeps good-packet / error-event counters.
module adc_pkt_rx
    import adc_pkt_pkg::*;
#(
    parameter int DATA_W = 18,
    parameter int LEN_W  = 11,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    input  logic              cfg_en,
    input  logic [1:0]        cfg_len_type,
    input  logic [3:0]        cfg_gap_min,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_sop,
    output logic              out_eop,
    output logic              out_abort,
    output logic              err_short,
    output logic              err_long,
    output logic              err_gap,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    logic [DATA_W-1:0] d_q;
    logic              v_q;

    rx_state_e   state_reg, state_next;
    logic [LEN_W-1:0] wcnt_reg, wcnt_next;
    logic [3:0]  gap_reg, gap_next;
    logic        first_pkt_reg, first_pkt_next;
    len_type_t   len_reg, len_next;
    // Set only when DROP is entered from a completed packet, so a
    // disabled burst never reports err_long and err_long fires once.
    logic        drop_first_reg, drop_first_next;

    logic [DATA_W-1:0] data_next;
    logic              valid_next, sop_next, eop_next, abort_next;
    logic              short_next, long_next, gap_err_next;

    logic [LEN_W-1:0] wcnt_plus;
    logic [LEN_W-1:0] exp_len_cur;

    assign wcnt_plus   = wcnt_reg + 1'b1;
    assign exp_len_cur = LEN_W'(exp_len(len_reg));

    // Register the pad inputs once before the FSM sees them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q <= '0;
            v_q <= 1'b0;
        end else begin
            d_q <= adc_data;
            v_q <= adc_valid;
        end
    end

    // FSM and bookkeeping state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            wcnt_reg       <= '0;
            gap_reg        <= '0;
            first_pkt_reg  <= 1'b1;
            len_reg        <= '0;
            drop_first_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wcnt_reg       <= wcnt_next;
            gap_reg        <= gap_next;
            first_pkt_reg  <= first_pkt_next;
            len_reg        <= len_next;
            drop_first_reg <= drop_first_next;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_next      = state_reg;
        wcnt_next       = wcnt_reg;
        gap_next        = gap_reg;
        first_pkt_next  = first_pkt_reg;
        len_next        = len_reg;
        drop_first_next = 1'b0;
        data_next       = '0;
        valid_next      = 1'b0;
        sop_next        = 1'b0;
        eop_next        = 1'b0;
        abort_next      = 1'b0;
        short_next      = 1'b0;
        long_next       = 1'b0;
        gap_err_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!v_q) begin
                    if (gap_reg != 4'hF) begin
                        gap_next = gap_reg + 4'd1;
                    end
                end else if (cfg_en) begin
                    valid_next     = 1'b1;
                    sop_next       = 1'b1;
                    data_next      = d_q;
                    wcnt_next      = LEN_W'(1);
                    len_next       = cfg_len_type;
                    gap_err_next   = !first_pkt_reg && (gap_reg < cfg_gap_min);
                    first_pkt_next = 1'b0;
                    gap_next       = '0;
                    state_next     = DATA;
                end else begin
                    // Disabled: swallow the rest of this burst silently
                    state_next = DROP;
                end
            end
            DATA: begin
                if (v_q) begin
                    valid_next = 1'b1;
                    data_next  = d_q;
                    wcnt_next  = wcnt_plus;
                    if (wcnt_plus == exp_len_cur) begin
                        eop_next        = 1'b1;
                        drop_first_next = 1'b1;
                        state_next      = DROP;
                    end
                end else begin
                    abort_next = 1'b1;
                    short_next = 1'b1;
                    gap_next   = 4'd1;
                    state_next = IDLE;
                end
            end
            DROP: begin
                if (v_q) begin
                    long_next = drop_first_reg;
                end else begin
                    gap_next   = 4'd1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered stream and error-pulse outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_abort <= 1'b0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
            err_gap   <= 1'b0;
        end else begin
            out_data  <= data_next;
            out_valid <= valid_next;
            out_sop   <= sop_next;
            out_eop   <= eop_next;
            out_abort <= abort_next;
            err_short <= short_next;
            err_long  <= long_next;
            err_gap   <= gap_err_next;
        end
    end

    sat_counter #(.W(CNT_W)) u_pkt_cnt (
        .clk (clk),
        .rst (rst),
        .inc (eop_next),
        .clr (1'b0),
        .q   (pkt_cnt)
    );

    // Error pulses are mutually exclusive per cycle, so one increment suffices
    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (short_next | long_next | gap_err_next),
        .clr (1'b0),
        .q   (err_cnt)
    );

endmodule
